// File: rtl/nios_system_cpu_mul_result_unit.sv
// Drives the 16x16 multiplier cell, then combines its partial products into the MUL low word or the MULX* high word.
// Latency: MUL result 2 cycles after accept; MULX 19 cycles (11 with NIOS_MUL_HH_RADIX4_EN, which selects the radix-4 hi*hi engine).
// Backpressure: one operation in flight; in_ready is low until the result handshake completes, and the result is held while out_ready is low.
module nios_system_cpu_mul_result_unit #(
  parameter int HH_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  input  logic        kill,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  output logic        mul_en,
  input  logic [31:0] mul_p1,
  input  logic [31:0] mul_p2,
  input  logic [31:0] mul_p3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result
);

  typedef enum logic [2:0] {S_IDLE, S_CAPT, S_HH, S_COMB, S_DONE} state_t;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULXSS = 2'd2;
  localparam logic [1:0] OP_MULXSU = 2'd3;

`ifdef NIOS_MUL_HH_RADIX4_EN
  localparam int HH_RADIX_BITS = 2;
`else
  localparam int HH_RADIX_BITS = 1;
`endif
  localparam int HH_STEPS = HH_WIDTH / HH_RADIX_BITS;
  localparam int CNT_W    = $clog2(HH_STEPS);

  state_t state_q, state_d;

  // Full operands are kept because the signed correction needs whole A and B.
  logic [1:0]            op_q;
  logic [31:0]           a_q, b_q;
  logic [HH_WIDTH-1:0]   p1_hi_q;
  logic [32:0]           s_q;
  logic [2*HH_WIDTH-1:0] hh_mcand, hh_acc, hh_add;
  logic [HH_WIDTH-1:0]   hh_mplier;
  logic [CNT_W-1:0]      hh_cnt;

  logic [32:0] cap_s;
  logic [31:0] mul_lo, corr, hi_res;
  logic        hh_last, lo_carry;

  assign mul_src1  = in_src1;
  assign mul_src2  = in_src2;
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign mul_en    = in_valid & in_ready & ~kill;

  assign cap_s   = {1'b0, mul_p2} + {1'b0, mul_p3};
  assign mul_lo  = mul_p1 + {cap_s[15:0], 16'h0000};
  assign hh_last = (hh_cnt == CNT_W'(HH_STEPS - 1));

  // Only p1[31:16] can carry into the high word: carry iff p1_hi + s_lo >= 2^16.
  assign lo_carry = (p1_hi_q > ~s_q[15:0]);

  always_comb begin
    corr = 32'h0;
    if ((op_q == OP_MULXSS || op_q == OP_MULXSU) && a_q[31])
      corr = corr + b_q;
    if (op_q == OP_MULXSS && b_q[31])
      corr = corr + a_q;
  end

  assign hi_res = hh_acc + {15'h0, s_q[32:16]} + {31'h0, lo_carry} - corr;

  always_comb begin
    hh_add = '0;
    for (int i = 0; i < HH_RADIX_BITS; i++) begin
      if (hh_mplier[i])
        hh_add = hh_add + (hh_mcand << i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = S_CAPT;
      S_CAPT: state_d = (op_q == OP_MUL) ? S_DONE : S_HH;
      S_HH:   if (hh_last) state_d = S_COMB;
      S_COMB: state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (kill)
      state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= 2'd0;
      a_q        <= 32'h0;
      b_q        <= 32'h0;
      p1_hi_q    <= '0;
      s_q        <= 33'h0;
      hh_mcand   <= '0;
      hh_mplier  <= '0;
      hh_acc     <= '0;
      hh_cnt     <= '0;
      out_result <= 32'h0;
    end else if (!kill) begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q <= in_op;
            a_q  <= in_src1;
            b_q  <= in_src2;
          end
        end
        S_CAPT: begin
          p1_hi_q <= mul_p1[31:16];
          s_q     <= cap_s;
          if (op_q == OP_MUL) begin
            out_result <= mul_lo;
          end else begin
            hh_mcand  <= {{HH_WIDTH{1'b0}}, b_q[2*HH_WIDTH-1 -: HH_WIDTH]};
            hh_mplier <= a_q[2*HH_WIDTH-1 -: HH_WIDTH];
            hh_acc    <= '0;
            hh_cnt    <= '0;
          end
        end
        S_HH: begin
          hh_acc    <= hh_acc + hh_add;
          hh_mcand  <= hh_mcand << HH_RADIX_BITS;
          hh_mplier <= hh_mplier >> HH_RADIX_BITS;
          hh_cnt    <= hh_cnt + CNT_W'(1);
        end
        S_COMB: out_result <= hi_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_system_cpu_mul_result_unit.sv
// Directed bench for nios_system_cpu_mul_result_unit with a behavioural multiplier cell attached.
module tb_nios_system_cpu_mul_result_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, kill, out_valid, out_ready, mul_en;
  logic [1:0]  in_op;
  logic [31:0] in_src1, in_src2, mul_src1, mul_src2, out_result;
  logic [31:0] cell_p1, cell_p2, cell_p3;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef NIOS_MUL_HH_RADIX4_EN
  localparam int MULX_LAT = 11;
`else
  localparam int MULX_LAT = 19;
`endif

  always #5 clk = ~clk;

  nios_system_cpu_mul_result_unit #(.HH_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .kill(kill),
    .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_en(mul_en),
    .mul_p1(cell_p1), .mul_p2(cell_p2), .mul_p3(cell_p3),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
  );

  // Multiplier cell: registered 16x16 partial products loaded on mul_en.
  always @(posedge clk) begin
    if (mul_en) begin
      cell_p1 <= {16'h0, mul_src1[15:0]}  * {16'h0, mul_src2[15:0]};
      cell_p2 <= {16'h0, mul_src1[15:0]}  * {16'h0, mul_src2[31:16]};
      cell_p3 <= {16'h0, mul_src1[31:16]} * {16'h0, mul_src2[15:0]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Offer one op, measure cycles until out_valid, check the word, then complete the handshake.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int cyc;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b;
    #1;
    chk({tag, "_en"}, {31'h0, mul_en}, 32'h1);
    chk({tag, "_src1"}, mul_src1, a);
    @(negedge clk);
    cyc = 1;
    chk({tag, "_en_busy"}, {31'h0, mul_en}, 32'h0);
    in_valid = 1'b0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(lat));
    chk({tag, "_res"}, out_result, exp);
    chk({tag, "_rdy_busy"}, {31'h0, in_ready}, 32'h0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_vld_drop"}, {31'h0, out_valid}, 32'h0);
    chk({tag, "_rdy_back"}, {31'h0, in_ready}, 32'h1);
  endtask

  initial begin
    int seen;
    reset_n = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
    in_op = 2'd0; in_src1 = 32'h0; in_src2 = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_vld", {31'h0, out_valid}, 32'h0);
    chk("rst_res", out_result, 32'h0);
    chk("rst_en", {31'h0, mul_en}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy", {31'h0, in_ready}, 32'h1);

    run_op("mul_basic", 2'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 2);
    run_op("mulxuu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MULX_LAT);
    run_op("mulxss_m1x2", 2'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MULX_LAT);
    run_op("mulxsu_m1", 2'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, MULX_LAT);
    run_op("mulxss_min", 2'd2, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MULX_LAT);
    run_op("mulxuu_mix", 2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, MULX_LAT);

    // Backpressure: result held, new offer refused.
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'd0; in_src1 = 32'h0000_0003; in_src2 = 32'h0000_0004;
    repeat (2) @(negedge clk);
    in_src1 = 32'h0000_0009;
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", {31'h0, out_valid}, 32'h1);
      chk("bp_res", out_result, 32'h0000_000C);
      chk("bp_rdy", {31'h0, in_ready}, 32'h0);
      chk("bp_en", {31'h0, mul_en}, 32'h0);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_vld_drop", {31'h0, out_valid}, 32'h0);
    chk("bp_rdy_back", {31'h0, in_ready}, 32'h1);

    // kill at T+5 of a MULXUU.
    in_valid = 1'b1; in_op = 2'd1; in_src1 = 32'hFFFF_FFFF; in_src2 = 32'hFFFF_FFFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_idle", {31'h0, in_ready}, 32'h1);
    chk("kill_vld", {31'h0, out_valid}, 32'h0);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("kill_no_result", 32'(seen), 32'h0);

    // kill with in_valid in IDLE blocks acceptance.
    in_valid = 1'b1; kill = 1'b1; in_op = 2'd0;
    #1;
    chk("kill_idle_en", {31'h0, mul_en}, 32'h0);
    @(negedge clk);
    chk("kill_idle_rdy", {31'h0, in_ready}, 32'h1);
    in_valid = 1'b0; kill = 1'b0;
    repeat (3) @(negedge clk);
    chk("kill_idle_vld", {31'h0, out_valid}, 32'h0);

    // Async reset at T+3 of a MULXSS.
    in_valid = 1'b1; in_op = 2'd2; in_src1 = 32'hFFFF_FFFF; in_src2 = 32'h0000_0002;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_res", out_result, 32'h0000_000C);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_vld", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_res", out_result, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op("mul_after_rst", 2'd0, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
